// File: rtl/memstream_sched_if.sv
// Control, flow-control and memory read-port signals of memstream_sched.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface memstream_sched_if #(
    parameter int unsigned NSTREAMS   = 4,
    parameter int unsigned ADDR_WIDTH = 14
);
    logic                  start;
    logic                  stop;
    logic                  rewind;
    logic [NSTREAMS-1:0]   strm_afull;
    logic                  config_ce;
    logic                  mem_ce;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  rd_vld;
    logic [1:0]            rd_strm;
    logic                  busy;
    logic                  done;

    modport master (
        output start, stop, rewind, strm_afull, config_ce,
        input  mem_ce, mem_addr, rd_vld, rd_strm, busy, done
    );

    modport slave (
        input  start, stop, rewind, strm_afull, config_ce,
        output mem_ce, mem_addr, rd_vld, rd_strm, busy, done
    );
endinterface

// File: rtl/memstream_sched.sv
// Round-robin memory read scheduler for up to four address streams, each
// walking a circular window [OFFSET, OFFSET+DEPTH) with a fixed 2-cycle read latency.
module memstream_sched #(
    parameter int unsigned NSTREAMS     = 4,
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned STRM0_OFFSET = 0,
    parameter int unsigned STRM1_OFFSET = 2304,
    parameter int unsigned STRM2_OFFSET = 4608,
    parameter int unsigned STRM3_OFFSET = 6912,
    parameter int unsigned STRM0_DEPTH  = 2304,
    parameter int unsigned STRM1_DEPTH  = 2304,
    parameter int unsigned STRM2_DEPTH  = 2304,
    parameter int unsigned STRM3_DEPTH  = 2304
) (
    input logic              aclk,
    input logic              aresetn,
    memstream_sched_if.slave bus
);
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CAND_W = 3;

    localparam logic [3:0][ADDR_WIDTH-1:0] OFFS = {
        ADDR_WIDTH'(STRM3_OFFSET), ADDR_WIDTH'(STRM2_OFFSET),
        ADDR_WIDTH'(STRM1_OFFSET), ADDR_WIDTH'(STRM0_OFFSET)
    };

    // Last word of each window; the pointer wraps back to OFFSET after it.
    localparam logic [3:0][ADDR_WIDTH-1:0] LAST = {
        ADDR_WIDTH'(STRM3_OFFSET + STRM3_DEPTH - 1), ADDR_WIDTH'(STRM2_OFFSET + STRM2_DEPTH - 1),
        ADDR_WIDTH'(STRM1_OFFSET + STRM1_DEPTH - 1), ADDR_WIDTH'(STRM0_OFFSET + STRM0_DEPTH - 1)
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                      state_q;
    state_t                      state_nxt;
    logic                        drain_exit_c;
    logic [3:0][ADDR_WIDTH-1:0]  ptr_q;
    logic [IDX_W-1:0]            last_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic                        vld1_q;
    logic                        vld2_q;
    logic [IDX_W-1:0]            idx1_q;
    logic [IDX_W-1:0]            idx2_q;
    logic                        done_q;
    logic [3:0]                  afull_pad;
    logic                        gnt_vld_c;
    logic [IDX_W-1:0]            gnt_idx_c;
    logic [CAND_W-1:0]           cand;

    assign afull_pad = 4'(bus.strm_afull);

    // Round-robin search starting one past the last granted stream.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        cand      = '0;
        for (int k = 1; k <= int'(NSTREAMS); k++) begin
            cand = CAND_W'(last_q) + CAND_W'(k);
            if (cand >= CAND_W'(NSTREAMS)) begin
                cand = cand - CAND_W'(NSTREAMS);
            end
            if (!gnt_vld_c && (state_q == S_RUN) && !bus.config_ce && !afull_pad[cand[IDX_W-1:0]]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // No grant is ever made outside RUN, so an empty pipeline alone ends DRAIN.
    always_comb begin
        state_nxt    = state_q;
        drain_exit_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!vld1_q && !vld2_q) begin
                    state_nxt    = S_IDLE;
                    drain_exit_c = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q  <= OFFS;
            last_q <= IDX_W'(NSTREAMS - 1);
            addr_q <= '0;
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            idx1_q <= '0;
            idx2_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= drain_exit_c;
            vld1_q <= gnt_vld_c;
            idx1_q <= gnt_idx_c;
            vld2_q <= vld1_q;
            idx2_q <= idx1_q;
            if (gnt_vld_c) begin
                last_q <= gnt_idx_c;
                addr_q <= ptr_q[gnt_idx_c];
            end
            // Rewind wins over the increment; the grant this cycle still used the old pointer.
            if (bus.rewind) begin
                ptr_q <= OFFS;
            end else if (gnt_vld_c) begin
                if (ptr_q[gnt_idx_c] == LAST[gnt_idx_c]) begin
                    ptr_q[gnt_idx_c] <= OFFS[gnt_idx_c];
                end else begin
                    ptr_q[gnt_idx_c] <= ptr_q[gnt_idx_c] + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign bus.mem_ce   = gnt_vld_c;
    assign bus.mem_addr = gnt_vld_c ? ptr_q[gnt_idx_c] : addr_q;
    assign bus.rd_vld   = vld2_q;
    assign bus.rd_strm  = idx2_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_memstream_sched.sv
// Bench for memstream_sched: directed vector table, hand sequences and random
// stimulus against a queue-free per-cycle reference model of the scheduling rules.
module tb_memstream_sched;
    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       rewind = 1'b0;
    logic       cfg = 1'b0;
    logic [3:0] afull = 4'h0;

    always #5 aclk = ~aclk;

    memstream_sched_if #(.NSTREAMS(4), .ADDR_WIDTH(14)) if0 ();
    memstream_sched_if #(.NSTREAMS(1), .ADDR_WIDTH(14)) if1 ();
    memstream_sched_if #(.NSTREAMS(3), .ADDR_WIDTH(14)) if2 ();

    assign if0.start = start;  assign if0.stop = stop;  assign if0.rewind = rewind;
    assign if0.config_ce = cfg; assign if0.strm_afull = afull;
    assign if1.start = start;  assign if1.stop = stop;  assign if1.rewind = rewind;
    assign if1.config_ce = cfg; assign if1.strm_afull = afull[0];
    assign if2.start = start;  assign if2.stop = stop;  assign if2.rewind = rewind;
    assign if2.config_ce = cfg; assign if2.strm_afull = afull[2:0];

    memstream_sched dut0 (.aclk(aclk), .aresetn(aresetn), .bus(if0));

    memstream_sched #(.NSTREAMS(1), .STRM0_OFFSET(10), .STRM0_DEPTH(3)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .bus(if1));

    memstream_sched #(.NSTREAMS(3), .STRM0_OFFSET(0), .STRM1_OFFSET(100), .STRM2_OFFSET(200),
                      .STRM0_DEPTH(5), .STRM1_DEPTH(1), .STRM2_DEPTH(7)) dut2 (
        .aclk(aclk), .aresetn(aresetn), .bus(if2));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Observed outputs of the DUT currently under test
    int cur;
    int o_ce, o_addr, o_vld, o_strm, o_busy, o_done;

    // Reference model: per-stream word counts modulo depth, grant history of two cycles
    int m_ns;
    int m_off[4];
    int m_dep[4];
    int m_phase;  // 0 idle, 1 running, 2 draining
    int m_n[4];
    int m_last;
    int m_g1, m_g2;
    int m_addr;
    int m_done;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (dut%0d, cycle %0d)", name, act, exp, cur, cyc);
        end
    endtask

    task automatic sample();
        case (cur)
            0: begin o_ce = int'(if0.mem_ce); o_addr = int'(if0.mem_addr); o_vld = int'(if0.rd_vld);
                     o_strm = int'(if0.rd_strm); o_busy = int'(if0.busy); o_done = int'(if0.done); end
            1: begin o_ce = int'(if1.mem_ce); o_addr = int'(if1.mem_addr); o_vld = int'(if1.rd_vld);
                     o_strm = int'(if1.rd_strm); o_busy = int'(if1.busy); o_done = int'(if1.done); end
            default: begin o_ce = int'(if2.mem_ce); o_addr = int'(if2.mem_addr); o_vld = int'(if2.rd_vld);
                     o_strm = int'(if2.rd_strm); o_busy = int'(if2.busy); o_done = int'(if2.done); end
        endcase
    endtask

    task automatic model_reset();
        m_phase = 0;
        for (int i = 0; i < 4; i++) m_n[i] = 0;
        m_last = m_ns - 1;
        m_g1 = -1;
        m_g2 = -1;
        m_addr = 0;
        m_done = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        sample();
        check({tag, ".mem_ce"}, o_ce, 0);
        check({tag, ".mem_addr"}, o_addr, 0);
        check({tag, ".rd_vld"}, o_vld, 0);
        check({tag, ".rd_strm"}, o_strm, 0);
        check({tag, ".busy"}, o_busy, 0);
        check({tag, ".done"}, o_done, 0);
    endtask

    task automatic select_dut(input int which);
        cur = which;
        case (which)
            0: begin m_ns = 4; m_off = '{0, 2304, 4608, 6912}; m_dep = '{2304, 2304, 2304, 2304}; end
            1: begin m_ns = 1; m_off = '{10, 0, 0, 0};         m_dep = '{3, 1, 1, 1}; end
            default: begin m_ns = 3; m_off = '{0, 100, 200, 0}; m_dep = '{5, 1, 7, 1}; end
        endcase
    endtask

    task automatic do_reset(input int which);
        select_dut(which);
        start = 0; stop = 0; rewind = 0; cfg = 0; afull = 4'h0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check_reset_outputs("reset");
        aresetn = 1'b1;
        model_reset();
    endtask

    // One clock: inputs already driven; compare at the falling edge, then advance the model.
    task automatic step();
        int g;
        int i;
        int e_addr;
        @(negedge aclk);
        sample();
        g = -1;
        if (m_phase == 1 && !cfg) begin
            for (int k = 1; k <= m_ns; k++) begin
                i = (m_last + k) % m_ns;
                if (g < 0 && !afull[i]) g = i;
            end
        end
        e_addr = (g >= 0) ? (m_off[g] + m_n[g]) % 16384 : m_addr;
        check("mem_ce", o_ce, (g >= 0) ? 1 : 0);
        check("mem_addr", o_addr, e_addr);
        check("rd_vld", o_vld, (m_g2 >= 0) ? 1 : 0);
        if (m_g2 >= 0) check("rd_strm", o_strm, m_g2);
        check("busy", o_busy, (m_phase != 0) ? 1 : 0);
        check("done", o_done, m_done);

        m_done = (m_phase == 2 && m_g1 < 0 && m_g2 < 0) ? 1 : 0;
        case (m_phase)
            0: if (start) m_phase = 1;
            1: if (stop) m_phase = 2;
            default: if (m_done != 0) m_phase = 0;
        endcase
        if (rewind) begin
            for (int s = 0; s < 4; s++) m_n[s] = 0;
        end else if (g >= 0) begin
            m_n[g] = (m_n[g] + 1) % m_dep[g];
        end
        if (g >= 0) begin
            m_last = g;
            m_addr = e_addr;
        end
        m_g2 = m_g1;
        m_g1 = g;
        @(posedge aclk);
        #1;
        cyc++;
        start = 0; stop = 0; rewind = 0;
    endtask

    typedef struct {
        bit start;
        bit stop;
        int ce;
        int addr;
        int vld;
        int strm;
        int busy;
        int done;
    } vec_t;

    vec_t tbl[14];
    int   exp36[6];
    int   exp35[7];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 0, 0,    0, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1, 0,    0, 0, 1, 0};
        tbl[2]  = '{1'b0, 1'b0, 1, 2304, 0, 0, 1, 0};
        tbl[3]  = '{1'b0, 1'b0, 1, 4608, 1, 0, 1, 0};
        tbl[4]  = '{1'b0, 1'b0, 1, 6912, 1, 1, 1, 0};
        tbl[5]  = '{1'b0, 1'b0, 1, 1,    1, 2, 1, 0};
        tbl[6]  = '{1'b0, 1'b0, 1, 2305, 1, 3, 1, 0};
        tbl[7]  = '{1'b0, 1'b0, 1, 4609, 1, 0, 1, 0};
        tbl[8]  = '{1'b0, 1'b0, 1, 6913, 1, 1, 1, 0};
        tbl[9]  = '{1'b0, 1'b1, 1, 2,    1, 2, 1, 0};
        tbl[10] = '{1'b0, 1'b0, 0, 2,    1, 3, 1, 0};
        tbl[11] = '{1'b0, 1'b0, 0, 2,    1, 0, 1, 0};
        tbl[12] = '{1'b0, 1'b0, 0, 2,    0, 0, 1, 0};
        tbl[13] = '{1'b0, 1'b0, 0, 2,    0, 0, 0, 1};
        exp36 = '{2304, 6912, 2305, 6913, 2306, 6914};
        exp35 = '{10, 11, 12, 10, 11, 12, 10};

        // Default configuration: address interleave, stop and drain
        do_reset(0);
        for (int r = 0; r < 14; r++) begin
            start = tbl[r].start;
            stop  = tbl[r].stop;
            step();
            check("tbl.mem_ce", o_ce, tbl[r].ce);
            check("tbl.mem_addr", o_addr, tbl[r].addr);
            check("tbl.rd_vld", o_vld, tbl[r].vld);
            if (tbl[r].vld != 0) check("tbl.rd_strm", o_strm, tbl[r].strm);
            check("tbl.busy", o_busy, tbl[r].busy);
            check("tbl.done", o_done, tbl[r].done);
        end
        step();
        check("done_one_cycle", o_done, 0);

        // Single stream with a 3-word window; rewind on the 6th grant
        do_reset(1);
        start = 1;
        step();
        for (int r = 0; r < 7; r++) begin
            if (r == 5) rewind = 1;
            step();
            check("wrap.mem_ce", o_ce, 1);
            check("wrap.mem_addr", o_addr, exp35[r]);
        end

        // Partial almost-full, then everything blocked
        do_reset(0);
        start = 1;
        step();
        afull = 4'b0101;
        for (int r = 0; r < 6; r++) begin
            step();
            check("afull.mem_addr", o_addr, exp36[r]);
        end
        afull = 4'b1111;
        repeat (3) begin
            step();
            check("blocked.mem_ce", o_ce, 0);
            check("blocked.busy", o_busy, 1);
        end

        // Config port steals three cycles without skipping an address
        afull = 4'b0000;
        step();
        check("cfg.pre0", o_addr, 0);
        step();
        check("cfg.pre1", o_addr, 2307);
        cfg = 1;
        repeat (3) begin
            step();
            check("cfg.mem_ce", o_ce, 0);
        end
        cfg = 0;
        step();
        check("cfg.resume_ce", o_ce, 1);
        check("cfg.resume_addr", o_addr, 4608);
        step();

        // Asynchronous reset with two reads in flight
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge aclk);
        #1;
        check_reset_outputs("midreset_hold");
        aresetn = 1'b1;
        model_reset();
        step();
        check("post_reset.idle_busy", o_busy, 0);
        start = 1;
        step();
        step();
        check("post_reset.mem_addr", o_addr, 0);

        // Random traffic on a 3-stream build with tiny windows (incl. depth 1)
        do_reset(2);
        for (int n = 0; n < 3000; n++) begin
            start  = ($urandom % 12) == 0;
            stop   = ($urandom % 40) == 0;
            rewind = ($urandom % 50) == 0;
            cfg    = ($urandom % 8) == 0;
            afull  = 4'($urandom) & 4'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
